// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline constants: sequencer state encoding,
// forward-select codes and the PC register index.
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hazState_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward select for one EXE operand; MEM wins over WB,
// and the PC is never forwarded.
module hazard_fwd_sel
    import hazard_sequencer_pkg::*;
(
    input  logic       enable,
    input  logic [3:0] readAddrE,
    input  logic       readValidE,
    input  logic [3:0] wa3M,
    input  logic       regWriteM,
    input  logic [3:0] wa3W,
    input  logic       regWriteW,
    output logic [1:0] forward
);

    logic hitM;
    logic hitW;

    assign hitM = regWriteM && readValidE
               && (readAddrE == wa3M) && (wa3M != REG_PC);
    assign hitW = regWriteW && readValidE
               && (readAddrE == wa3W) && (wa3W != REG_PC);

    always_comb begin
        forward = FWD_RF;
        if (enable) begin
            if (hitM)
                forward = FWD_MEM;
            else if (hitW)
                forward = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: post-reset drain, load-use,
// branch flush, memory-wait stalls and EXE forwarding.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             ReadAddr1D,
    input  logic [3:0]             ReadAddr2D,
    input  logic                   IsReadAddr1_ValidD,
    input  logic                   IsReadAddr2_ValidD,
    input  logic [3:0]             ReadAddr1E,
    input  logic [3:0]             ReadAddr2E,
    input  logic                   IsReadAddr1_ValidE,
    input  logic                   IsReadAddr2_ValidE,
    input  logic [3:0]             WA3E,
    input  logic [3:0]             WA3M,
    input  logic [3:0]             WA3W,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemtoRegE,
    input  logic                   BranchTakenE,
    input  logic                   MemReqM,
    input  logic                   mem_ack,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   StallM,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushW,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT);

    hazState_e state;
    hazState_e nextState;
    logic [3:0] initCnt;
    logic [7:0] waitCnt;
    logic lduse;
    logic timeout;
    logic fwdEn;

    assign lduse = MemtoRegE && RegWriteE
        && ((IsReadAddr1_ValidD && (ReadAddr1D == WA3E))
         || (IsReadAddr2_ValidD && (ReadAddr2D == WA3E)));

    assign fwdEn = !reset && (state != INIT);

    always_comb begin
        nextState = state;
        timeout   = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (reset) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            unique case (state)
                INIT: begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    FlushW = 1'b1;
                    if (initCnt == INIT_LAST)
                        nextState = RUN;
                end
                RUN: begin
                    if (MemReqM && !mem_ack) begin
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        StallE    = 1'b1;
                        StallM    = 1'b1;
                        FlushW    = 1'b1;
                        nextState = MEM_WAIT;
                    end else if (BranchTakenE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lduse) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        nextState = RUN;
                    end else if (waitCnt == WAIT_LAST) begin
                        // Abandon the access: let the pipe advance.
                        timeout   = 1'b1;
                        nextState = RUN;
                    end else begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end
                end
                default: nextState = INIT;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state        <= INIT;
            initCnt      <= '0;
            waitCnt      <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= nextState;
            if (state == INIT)
                initCnt <= initCnt + 4'd1;
            else
                initCnt <= '0;
            if (state == RUN && nextState == MEM_WAIT)
                waitCnt <= 8'd1;
            else if (state == MEM_WAIT && nextState == MEM_WAIT)
                waitCnt <= waitCnt + 8'd1;
            else
                waitCnt <= '0;
            if (timeout)
                mem_err <= 1'b1;
            if (StallF && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    hazard_fwd_sel u_fwdA (
        .enable     (fwdEn),
        .readAddrE  (ReadAddr1E),
        .readValidE (IsReadAddr1_ValidE),
        .wa3M       (WA3M),
        .regWriteM  (RegWriteM),
        .wa3W       (WA3W),
        .regWriteW  (RegWriteW),
        .forward    (ForwardAE)
    );

    hazard_fwd_sel u_fwdB (
        .enable     (fwdEn),
        .readAddrE  (ReadAddr2E),
        .readValidE (IsReadAddr2_ValidE),
        .wa3M       (WA3M),
        .regWriteM  (RegWriteM),
        .wa3W       (WA3W),
        .regWriteW  (RegWriteW),
        .forward    (ForwardBE)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: drain, forwarding,
// load-use, branch, memory wait, timeout and reset.
module tb_hazard_sequencer;

    logic clk;
    logic reset;
    logic [3:0] ReadAddr1D, ReadAddr2D, ReadAddr1E, ReadAddr2E;
    logic IsReadAddr1_ValidD, IsReadAddr2_ValidD;
    logic IsReadAddr1_ValidE, IsReadAddr2_ValidE;
    logic [3:0] WA3E, WA3M, WA3W;
    logic RegWriteE, RegWriteM, RegWriteW;
    logic MemtoRegE, BranchTakenE, MemReqM, mem_ack;
    logic StallF, StallD, StallE, StallM;
    logic FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic mem_err;
    logic [15:0] stall_cycles;
    logic [6:0] ctrl;

    int checks = 0;
    int errors = 0;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_INIT = 7'b1000111;
    localparam logic [6:0] C_LDU  = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    assign ctrl = {StallF, StallD, StallE, StallM,
                   FlushD, FlushE, FlushW};

    hazard_sequencer #(
        .INIT_CYCLES (4),
        .MEM_TIMEOUT (16),
        .STALL_CNT_W (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ReadAddr1D         (ReadAddr1D),
        .ReadAddr2D         (ReadAddr2D),
        .IsReadAddr1_ValidD (IsReadAddr1_ValidD),
        .IsReadAddr2_ValidD (IsReadAddr2_ValidD),
        .ReadAddr1E         (ReadAddr1E),
        .ReadAddr2E         (ReadAddr2E),
        .IsReadAddr1_ValidE (IsReadAddr1_ValidE),
        .IsReadAddr2_ValidE (IsReadAddr2_ValidE),
        .WA3E               (WA3E),
        .WA3M               (WA3M),
        .WA3W               (WA3W),
        .RegWriteE          (RegWriteE),
        .RegWriteM          (RegWriteM),
        .RegWriteW          (RegWriteW),
        .MemtoRegE          (MemtoRegE),
        .BranchTakenE       (BranchTakenE),
        .MemReqM            (MemReqM),
        .mem_ack            (mem_ack),
        .StallF             (StallF),
        .StallD             (StallD),
        .StallE             (StallE),
        .StallM             (StallM),
        .FlushD             (FlushD),
        .FlushE             (FlushE),
        .FlushW             (FlushW),
        .ForwardAE          (ForwardAE),
        .ForwardBE          (ForwardBE),
        .mem_err            (mem_err),
        .stall_cycles       (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearIns();
        ReadAddr1D = '0; ReadAddr2D = '0;
        ReadAddr1E = '0; ReadAddr2E = '0;
        IsReadAddr1_ValidD = 1'b0; IsReadAddr2_ValidD = 1'b0;
        IsReadAddr1_ValidE = 1'b0; IsReadAddr2_ValidE = 1'b0;
        WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; BranchTakenE = 1'b0;
        MemReqM = 1'b0; mem_ack = 1'b0;
    endtask

    // Inputs change just after the falling (active) edge,
    // outputs are sampled on the rising edge mid-cycle.
    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic sample();
        @(posedge clk);
    endtask

    initial begin
        clearIns();
        reset = 1'b1;
        sample();
        check("reset_ctrl", 32'(ctrl), 32'(C_INIT));
        nextCycle();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            sample();
            check("init_ctrl", 32'(ctrl), 32'(C_INIT));
            check("init_cnt", 32'(stall_cycles), 32'(i));
            nextCycle();
        end
        sample();
        check("run_ctrl", 32'(ctrl), 32'(C_NONE));
        check("run_cnt", 32'(stall_cycles), 32'd4);
        check("run_err", 32'(mem_err), 32'd0);
        nextCycle();

        RegWriteM = 1'b1; WA3M = 4'd3;
        RegWriteW = 1'b1; WA3W = 4'd3;
        ReadAddr1E = 4'd3; IsReadAddr1_ValidE = 1'b1;
        sample();
        check("fwdA_mem", 32'(ForwardAE), 32'd2);
        check("fwdB_idle", 32'(ForwardBE), 32'd0);
        nextCycle();
        WA3M = 4'd7;
        sample();
        check("fwdA_wb", 32'(ForwardAE), 32'd1);
        nextCycle();
        WA3M = 4'd15; WA3W = 4'd15; ReadAddr1E = 4'd15;
        sample();
        check("fwdA_pc", 32'(ForwardAE), 32'd0);
        nextCycle();
        RegWriteM = 1'b0; WA3W = 4'd4;
        ReadAddr2E = 4'd4; IsReadAddr2_ValidE = 1'b1;
        sample();
        check("fwdB_wb", 32'(ForwardBE), 32'd1);
        nextCycle();
        IsReadAddr2_ValidE = 1'b0;
        sample();
        check("fwdB_novalid", 32'(ForwardBE), 32'd0);
        nextCycle();

        clearIns();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5;
        ReadAddr2D = 4'd5; IsReadAddr2_ValidD = 1'b1;
        sample();
        check("lduse", 32'(ctrl), 32'(C_LDU));
        nextCycle();
        BranchTakenE = 1'b1;
        sample();
        check("branch_over_lduse", 32'(ctrl), 32'(C_BR));
        nextCycle();
        BranchTakenE = 1'b0; IsReadAddr2_ValidD = 1'b0;
        sample();
        check("lduse_novalid", 32'(ctrl), 32'(C_NONE));
        check("cnt_after_lduse", 32'(stall_cycles), 32'd5);
        nextCycle();

        clearIns();
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("memwait", 32'(ctrl), 32'(C_MEM));
            nextCycle();
        end
        mem_ack = 1'b1;
        sample();
        check("mem_ack", 32'(ctrl), 32'(C_NONE));
        nextCycle();
        MemReqM = 1'b0; mem_ack = 1'b0;
        sample();
        check("after_ack", 32'(ctrl), 32'(C_NONE));
        check("after_ack_err", 32'(mem_err), 32'd0);
        check("after_ack_cnt", 32'(stall_cycles), 32'd8);
        nextCycle();

        MemReqM = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sample();
            check("timeout_wait", 32'(ctrl), 32'(C_MEM));
            nextCycle();
        end
        sample();
        check("timeout_release", 32'(ctrl), 32'(C_NONE));
        check("timeout_err_pre", 32'(mem_err), 32'd0);
        nextCycle();
        MemReqM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("timeout_err", 32'(mem_err), 32'd1);
            check("timeout_ctrl", 32'(ctrl), 32'(C_NONE));
            nextCycle();
        end
        sample();
        check("timeout_cnt", 32'(stall_cycles), 32'd24);
        nextCycle();

        MemReqM = 1'b1;
        sample();
        check("rst_enter_wait", 32'(ctrl), 32'(C_MEM));
        nextCycle();
        sample();
        check("rst_wait1", 32'(ctrl), 32'(C_MEM));
        nextCycle();
        reset = 1'b1;
        sample();
        check("rst_mid_ctrl", 32'(ctrl), 32'(C_INIT));
        nextCycle();
        reset = 1'b0; MemReqM = 1'b0;
        sample();
        check("rst_init_err", 32'(mem_err), 32'd0);
        check("rst_init_cnt", 32'(stall_cycles), 32'd0);
        check("rst_init_ctrl", 32'(ctrl), 32'(C_INIT));
        RegWriteM = 1'b1; WA3M = 4'd2;
        ReadAddr1E = 4'd2; IsReadAddr1_ValidE = 1'b1;
        check("rst_init_nofwd", 32'(ForwardAE), 32'd0);
        nextCycle();
        for (int i = 1; i < 4; i++) begin
            sample();
            check("rst_init_hold", 32'(ctrl), 32'(C_INIT));
            nextCycle();
        end
        sample();
        check("rst_rerun", 32'(ctrl), 32'(C_NONE));
        check("rst_rerun_fwd", 32'(ForwardAE), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
